// File: rtl/ser_pkg.sv
// Shared definitions for the parametrised serializer: state encoding,
// parity type constants and the effective-length rule.
package ser_pkg;

  typedef logic [0:0] ser_state_t;

  localparam ser_state_t ST_IDLE  = 1'b0;
  localparam ser_state_t ST_SHIFT = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Length 0 means a full word; anything longer than the word is clamped.
  function automatic int unsigned ser_eff_len(input int unsigned len,
                                              input int unsigned dw);
    return ((len == 0) || (len > dw)) ? dw : len;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: clear, Tick-gated increment,
// and a terminal flag when the count reaches len-1. Saturates there.
module ser_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign term = (cnt_q == (len - CNT_W'(1)));
  assign cnt  = cnt_q;

  // Clear wins; otherwise advance on an enabled Tick but never past len-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)               cnt_d = '0;
    else if (inc && !term) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/param_serializer.sv
// Parallel-in/serial-out engine with valid/ready load, runtime frame
// length, selectable bit order, Tick-paced shifting, abort and done strobe.
// Optional parity output enabled by defining SER_PARITY_EN.
module param_serializer
  import ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic [CNT_W-1:0]      Data_Len,
  input  logic                  MSB_First,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic                  Tick,
  input  logic                  Abort,
`ifdef SER_PARITY_EN
  input  logic                  Par_Type,
  output logic                  Par_Bit,
`endif
  output logic                  S_Data,
  output logic                  S_Busy,
  output logic                  S_Done
);

  ser_state_t            state_d, state_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic [CNT_W-1:0]      len_d, len_q;
  logic                  msb_d, msb_q;
  logic                  sdata_d, sdata_q;
  logic                  done_d, done_q;

  logic [CNT_W-1:0]      ld_len;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_term;
  logic                  ld_fire, tk_fire;
  logic [CNT_W-1:0]      ld_idx, nxt_idx;
  logic                  ld_bit, nxt_bit;

  assign ld_len  = CNT_W'(ser_eff_len(32'(Data_Len), DATA_WIDTH));
  assign ld_fire = (state_q == ST_IDLE)  && Data_Valid && !Abort;
  assign tk_fire = (state_q == ST_SHIFT) && Tick && !Abort;

  ser_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (ld_fire | Abort | (tk_fire & cnt_term)),
    .inc   (tk_fire),
    .len   (len_q),
    .cnt   (cnt),
    .term  (cnt_term)
  );

  // First bit to present on the load edge and the next bit after a Tick.
  // Variable selects are unrolled so index width never matters.
  always_comb begin
    ld_idx  = MSB_First ? (ld_len - CNT_W'(1)) : '0;
    nxt_idx = msb_q ? (len_q - CNT_W'(2) - cnt) : (cnt + CNT_W'(1));
    ld_bit  = 1'b0;
    nxt_bit = 1'b0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (ld_idx  == CNT_W'(i)) ld_bit  = P_Data[i];
      if (nxt_idx == CNT_W'(i)) nxt_bit = data_q[i];
    end
  end

  // Frame FSM: Abort overrides everything; load only from IDLE; Tick only
  // advances in SHIFT, and the terminal Tick returns to IDLE with done.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    msb_d   = msb_q;
    sdata_d = sdata_q;
    done_d  = 1'b0;
    if (Abort) begin
      state_d = ST_IDLE;
      sdata_d = IDLE_LEVEL;
    end else if (state_q == ST_IDLE) begin
      sdata_d = IDLE_LEVEL;
      if (Data_Valid) begin
        state_d = ST_SHIFT;
        data_d  = P_Data;
        len_d   = ld_len;
        msb_d   = MSB_First;
        sdata_d = ld_bit;
      end
    end else if (Tick) begin
      if (cnt_term) begin
        state_d = ST_IDLE;
        sdata_d = IDLE_LEVEL;
        done_d  = 1'b1;
      end else begin
        sdata_d = nxt_bit;
      end
    end
  end

  // Frame state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      len_q   <= CNT_W'(DATA_WIDTH);
      msb_q   <= 1'b0;
      sdata_q <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
      sdata_q <= sdata_d;
      done_q  <= done_d;
    end
  end

  assign S_Data     = sdata_q;
  assign S_Done     = done_q;
  assign S_Busy     = (state_q == ST_SHIFT);
  assign Data_Ready = (state_q == ST_IDLE);

`ifdef SER_PARITY_EN
  logic par_d, par_q;

  // Parity over the active bits only, captured at load and held after
  // abort until the next load.
  always_comb begin
    par_d = par_q;
    if (ld_fire) begin
      par_d = Par_Type;
      for (int i = 0; i < int'(DATA_WIDTH); i++)
        if (CNT_W'(i) < ld_len) par_d = par_d ^ P_Data[i];
    end
  end

  // Parity register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  assign Par_Bit = par_q;
`endif

endmodule
